// File: rtl/bit_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bit_count_ctrl
//  Description : Key/switch front-end for bit_count: synchronises, debounces,
//                sequences the s/done handshake and holds the last count.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_count_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int TIMEOUT   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_start,
    input  logic [7:0] sw_data,
    output logic       s,
    output logic [7:0] data,
    input  logic [3:0] result,
    input  logic       done,
    output logic [3:0] count_out,
    output logic       valid,
    output logic       error,
    output logic       busy,
    output logic [7:0] run_cnt,
    output logic [6:0] hex
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam int TM_W = $clog2(TIMEOUT + 1);
    localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [TM_W-1:0] c_TM_LAST = TM_W'(TIMEOUT - 1);
    localparam logic [6:0] c_HEX_E    = 7'b0000110;
    localparam logic [6:0] c_HEX_DASH = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_RUN     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t          state_q;
    logic            key_meta_q, key_sync_q;
    logic [7:0]      sw_meta_q, sw_sync_q;
    logic            key_db_q, key_db_d, key_db_dly_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [TM_W-1:0] timer_q;
    logic            s_q, valid_q, error_q, busy_q;
    logic [7:0]      data_q, run_cnt_q;
    logic [3:0]      count_q;
    logic            w_start;
    logic [6:0]      w_hex;

    // The stability counter restarts whenever the synchronised key agrees again.
    always_comb begin
        key_db_d = key_db_q;
        db_cnt_d = '0;
        if (key_sync_q != key_db_q) begin
            if (db_cnt_q == c_DB_LAST) begin
                key_db_d = key_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign w_start = key_db_q & ~key_db_dly_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_meta_q   <= 1'b0;
            key_sync_q   <= 1'b0;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            key_db_q     <= 1'b0;
            key_db_dly_q <= 1'b0;
            db_cnt_q     <= '0;
        end else begin
            key_meta_q   <= key_start;
            key_sync_q   <= key_meta_q;
            sw_meta_q    <= sw_data;
            sw_sync_q    <= sw_meta_q;
            key_db_q     <= key_db_d;
            key_db_dly_q <= key_db_q;
            db_cnt_q     <= db_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            s_q       <= 1'b0;
            data_q    <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            run_cnt_q <= '0;
            timer_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    data_q <= sw_sync_q;
                    if (w_start) begin
                        state_q <= ST_SETUP;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        error_q <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_RUN;
                    s_q     <= 1'b1;
                    timer_q <= '0;
                end
                ST_RUN: begin
                    timer_q <= timer_q + 1'b1;
                    // result is only valid while s is high, so capture on first done.
                    if (done) begin
                        count_q   <= result;
                        valid_q   <= 1'b1;
                        run_cnt_q <= run_cnt_q + 8'd1;
                        s_q       <= 1'b0;
                        state_q   <= ST_RELEASE;
                    end else if (timer_q == c_TM_LAST) begin
                        error_q <= 1'b1;
                        valid_q <= 1'b0;
                        s_q     <= 1'b0;
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!done) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_hex = c_HEX_DASH;
        if (error_q) begin
            w_hex = c_HEX_E;
        end else if (valid_q) begin
            case (count_q)
                4'd0:    w_hex = 7'b1000000;
                4'd1:    w_hex = 7'b1111001;
                4'd2:    w_hex = 7'b0100100;
                4'd3:    w_hex = 7'b0110000;
                4'd4:    w_hex = 7'b0011001;
                4'd5:    w_hex = 7'b0010010;
                4'd6:    w_hex = 7'b0000010;
                4'd7:    w_hex = 7'b1111000;
                4'd8:    w_hex = 7'b0000000;
                default: w_hex = c_HEX_DASH;
            endcase
        end
    end

    assign s         = s_q;
    assign data      = data_q;
    assign count_out = count_q;
    assign valid     = valid_q;
    assign error     = error_q;
    assign busy      = busy_q;
    assign run_cnt   = run_cnt_q;
    assign hex       = w_hex;

endmodule
`default_nettype wire

// File: tb/tb_bit_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_count_ctrl
//  Description : Scoreboard bench for bit_count_ctrl with a bit_count stand-in.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_count_ctrl;

    localparam int TO = 32;

    logic       clk = 1'b0;
    logic       reset, key_start, done;
    logic [7:0] sw_data, data, run_cnt;
    logic [3:0] result, count_out;
    logic       s, valid, error, busy;
    logic [6:0] hex;

    always #5 clk = ~clk;

    bit_count_ctrl #(.DB_CYCLES(4), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .key_start(key_start), .sw_data(sw_data),
        .s(s), .data(data), .result(result), .done(done),
        .count_out(count_out), .valid(valid), .error(error), .busy(busy),
        .run_cnt(run_cnt), .hex(hex)
    );

    typedef struct {
        logic [7:0] op;
        logic [3:0] cnt;
        logic       vld;
        logic       err;
        logic [7:0] runs;
        int         slen;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // display-state reference
    logic [3:0] m_cnt;
    logic       m_vld, m_err;
    int         m_runs;

    // bit_count stand-in knobs and state
    int         bc_lat;
    bit         bc_force;
    logic [3:0] bc_val;
    logic [7:0] bc_op;
    int         bc_age;
    bit         bc_active;

    bit   mon_busy_p;
    int   mon_slen;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] hex_of(input logic err, input logic vld, input logic [3:0] v);
        if (err) return 7'b0000110;
        if (!vld) return 7'b0111111;
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Stand-in for bit_count: answers lat cycles after s rises (lat=0 never answers).
    initial begin
        done = 1'b0; result = '0; bc_active = 1'b0; bc_age = 0; bc_op = '0;
        forever begin
            @(negedge clk);
            if (reset || !s) begin
                done = 1'b0; result = '0; bc_active = 1'b0; bc_age = 0;
            end else begin
                if (!bc_active) begin
                    bc_active = 1'b1;
                    bc_op     = data;
                end
                bc_age++;
                if (bc_lat > 0 && bc_age == bc_lat) begin
                    done   = 1'b1;
                    result = bc_force ? bc_val : 4'($countones(bc_op));
                end
            end
        end
    end

    // Monitor: a run is complete when busy falls.
    initial begin
        mon_busy_p = 1'b0; mon_slen = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_busy_p = 1'b0; mon_slen = 0;
            end else begin
                if (s) mon_slen++;
                if (mon_busy_p && !busy) begin
                    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        mon_e = sb.pop_front();
                        check("operand",   32'(bc_op),     32'(mon_e.op));
                        check("data_hold", 32'(data),      32'(mon_e.op));
                        check("count_out", 32'(count_out), 32'(mon_e.cnt));
                        check("valid",     32'(valid),     32'(mon_e.vld));
                        check("error",     32'(error),     32'(mon_e.err));
                        check("run_cnt",   32'(run_cnt),   32'(mon_e.runs));
                        check("hex",       32'(hex),       32'(hex_of(mon_e.err, mon_e.vld, mon_e.cnt)));
                        check("s_high_len", 32'(mon_slen), 32'(mon_e.slen));
                        check("s_low",     32'(s),         32'd0);
                    end
                    mon_slen = 0;
                end
                mon_busy_p = busy;
            end
        end
    end

    task automatic plan_run(input logic [7:0] d, input int lat, input bit force_bad);
        exp_t e;
        sw_data  = d;
        bc_lat   = lat;
        bc_force = force_bad;
        bc_val   = 4'($urandom_range(9, 15));
        e.op     = d;
        if (lat > 0 && lat <= TO) begin
            m_cnt  = force_bad ? bc_val : 4'($countones(d));
            m_vld  = 1'b1;
            m_err  = 1'b0;
            m_runs = (m_runs + 1) % 256;
            e.slen = lat;
        end else begin
            m_vld  = 1'b0;
            m_err  = 1'b1;
            e.slen = TO;
        end
        e.cnt  = m_cnt;
        e.vld  = m_vld;
        e.err  = m_err;
        e.runs = 8'(m_runs);
        sb.push_back(e);
    endtask

    task automatic press(input int hold, input int gap, output int s_at);
        s_at = -1;
        key_start = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (s && s_at < 0) s_at = i;
        end
        key_start = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("idle_within_bound", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int sa;
        int seen;
        reset = 1'b1; key_start = 1'b0; sw_data = '0;
        bc_lat = 0; bc_force = 1'b0; bc_val = '0;
        m_cnt = '0; m_vld = 1'b0; m_err = 1'b0; m_runs = 0;

        #2;
        check("rst_s",       32'(s),         32'd0);
        check("rst_data",    32'(data),      32'd0);
        check("rst_count",   32'(count_out), 32'd0);
        check("rst_valid",   32'(valid),     32'd0);
        check("rst_error",   32'(error),     32'd0);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_run_cnt", 32'(run_cnt),   32'd0);
        check("rst_hex",     32'(hex),       32'h3F);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // nominal run
        plan_run(8'h5B, 6, 1'b0);
        press(20, 8, sa);
        check("start_latency", 32'(sa), 32'd8);
        wait_idle();

        // bounced press yields one run
        plan_run(8'($urandom), 5, 1'b0);
        key_start = 1'b1; @(negedge clk);
        key_start = 1'b0; @(negedge clk);
        key_start = 1'b1; @(negedge clk);
        press(12, 8, sa);
        wait_idle();

        // short glitch is rejected
        key_start = 1'b1;
        repeat (2) @(negedge clk);
        key_start = 1'b0;
        seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (busy) seen++;
        end
        check("glitch_no_start", 32'(seen), 32'd0);

        // timeout and done-vs-timeout boundary
        plan_run(8'($urandom), 0, 1'b0);
        press(8, 8, sa);
        wait_idle();
        plan_run(8'($urandom), 32, 1'b0);
        press(8, 8, sa);
        wait_idle();
        plan_run(8'($urandom), 33, 1'b0);
        press(8, 8, sa);
        wait_idle();
        plan_run(8'($urandom), 31, 1'b0);
        press(8, 8, sa);
        wait_idle();

        // isolation: second press and switch change during RUN
        plan_run(8'h5B, 28, 1'b0);
        press(8, 0, sa);
        check("iso_start_latency", 32'(sa), 32'd8);
        sw_data = 8'hFF;
        repeat (8) @(negedge clk);
        press(10, 0, sa);
        check("iso_still_busy", 32'(busy), 32'd1);
        repeat (8) @(negedge clk);
        wait_idle();
        repeat (3) @(negedge clk);
        check("idle_reload", 32'(data), 32'hFF);

        // out-of-range result and random runs
        plan_run(8'($urandom), 4, 1'b1);
        press(8, 8, sa);
        wait_idle();
        for (int i = 0; i < 12; i++) begin
            plan_run(8'($urandom), int'($urandom_range(0, 34)), ($urandom_range(0, 5) == 0));
            press(8, 8, sa);
            check("rand_start_latency", 32'(sa), 32'd8);
            wait_idle();
        end

        // asynchronous reset in the middle of RUN
        bc_lat = 0;
        key_start = 1'b1;
        repeat (10) @(negedge clk);
        key_start = 1'b0;
        check("pre_reset_s", 32'(s), 32'd1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_s",       32'(s),       32'd0);
        check("arst_valid",   32'(valid),   32'd0);
        check("arst_busy",    32'(busy),    32'd0);
        check("arst_run_cnt", 32'(run_cnt), 32'd0);
        check("arst_hex",     32'(hex),     32'h3F);
        check("arst_data",    32'(data),    32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_cnt = '0; m_vld = 1'b0; m_err = 1'b0; m_runs = 0;
        repeat (10) @(negedge clk);

        // max count, then 256 runs to wrap run_cnt
        plan_run(8'hFF, 5, 1'b0);
        press(8, 8, sa);
        wait_idle();
        for (int i = 0; i < 256; i++) begin
            plan_run(8'($urandom), int'($urandom_range(1, 3)), 1'b0);
            press(8, 8, sa);
            wait_idle();
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
